// File: rtl/barrel_shift_pipe.sv
// Purpose     : pipelined logarithmic barrel shifter (SLL/SRL/SRA/ROR); stage k shifts by 2^k when shamt[k]=1.
// Latency     : SHW cycles from issue to out_valid, 1 op/cycle sustained throughput.
// Backpressure: one global advance enable; out_valid & !out_ready freezes every stage and drops in_ready.
//
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   in_valid/in_ready              upstream handshake; in_data, in_shamt, in_op (00 SLL, 01 SRL, 10 SRA, 11 ROR)
//   out_valid/out_ready            downstream handshake; out_data result
//   out_zero                       only with BSH_ZERO_FLAG_EN defined: registered (result == 0), qualified by out_valid
`timescale 1ns/1ps

module barrel_shift_pipe #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef BSH_ZERO_FLAG_EN
  ,
  output logic             out_zero
`endif
);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  // One fixed-distance shift step. sh is always a power of two in 1..WIDTH/2,
  // so the ROR left-shift distance WIDTH-sh never reaches WIDTH.
  function automatic logic [WIDTH-1:0] f_shift(
    input logic [WIDTH-1:0] d,
    input logic [1:0]       op,
    input logic             sgn,
    input int unsigned      sh
  );
    logic [WIDTH-1:0] res;
    res = '0;
    case (op)
      OP_SLL:  res = d << sh;
      OP_SRL:  res = d >> sh;
      // Vacated top bits take the entry's original MSB, not this stage's input MSB.
      OP_SRA:  res = (d >> sh) | ({WIDTH{sgn}} & ~({WIDTH{1'b1}} >> sh));
      default: res = (d >> sh) | (d << (WIDTH - sh));
    endcase
    return res;
  endfunction

  logic w_advance;

  // Per-stage sources: stage 0 reads the input port, stage k reads stage k-1.
  logic             w_src_vld   [SHW];
  logic [WIDTH-1:0] w_src_dat   [SHW];
  logic [1:0]       w_src_op    [SHW];
  logic [SHW-1:0]   w_src_shamt [SHW];
  logic             w_src_sgn   [SHW];
  logic [WIDTH-1:0] w_nxt_dat   [SHW];

  // The last stage only needs valid and data, so op/shamt/sign stop one short.
  logic             r_vld   [SHW];
  logic [WIDTH-1:0] r_dat   [SHW];
  logic [1:0]       r_op    [SHW-1];
  logic [SHW-1:0]   r_shamt [SHW-1];
  logic             r_sgn   [SHW-1];

  assign w_advance = !r_vld[SHW-1] || out_ready;
  assign in_ready  = w_advance;
  assign out_valid = r_vld[SHW-1];
  assign out_data  = r_dat[SHW-1];

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign w_src_vld[k]   = in_valid;
      assign w_src_dat[k]   = in_data;
      assign w_src_op[k]    = in_op;
      assign w_src_shamt[k] = in_shamt;
      assign w_src_sgn[k]   = in_data[WIDTH-1];
    end else begin : g_next
      assign w_src_vld[k]   = r_vld[k-1];
      assign w_src_dat[k]   = r_dat[k-1];
      assign w_src_op[k]    = r_op[k-1];
      assign w_src_shamt[k] = r_shamt[k-1];
      assign w_src_sgn[k]   = r_sgn[k-1];
    end
    assign w_nxt_dat[k] = w_src_shamt[k][k] ?
                          f_shift(w_src_dat[k], w_src_op[k], w_src_sgn[k], 1 << k) :
                          w_src_dat[k];
  end

  // Bubbles load zeros so idle stages (and out_data while out_valid=0) stay at 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < SHW; k++) begin
        r_vld[k] <= 1'b0;
        r_dat[k] <= '0;
      end
      for (int k = 0; k < SHW-1; k++) begin
        r_op[k]    <= '0;
        r_shamt[k] <= '0;
        r_sgn[k]   <= 1'b0;
      end
    end else if (w_advance) begin
      for (int k = 0; k < SHW; k++) begin
        r_vld[k] <= w_src_vld[k];
        r_dat[k] <= w_src_vld[k] ? w_nxt_dat[k] : '0;
      end
      for (int k = 0; k < SHW-1; k++) begin
        r_op[k]    <= w_src_vld[k] ? w_src_op[k]    : '0;
        r_shamt[k] <= w_src_vld[k] ? w_src_shamt[k] : '0;
        r_sgn[k]   <= w_src_vld[k] && w_src_sgn[k];
      end
    end
  end

`ifdef BSH_ZERO_FLAG_EN
  // Computed from the final stage's next data so it lands with the result it describes.
  logic r_zero;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_zero <= 1'b0;
    end else if (w_advance) begin
      r_zero <= w_src_vld[SHW-1] && (w_nxt_dat[SHW-1] == '0);
    end
  end

  assign out_zero = r_zero;
`endif

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Purpose     : self-checking bench for barrel_shift_pipe (WIDTH=8, SHW=3).
// Latency     : expects results 3 cycles after issue with no stalls.
// Backpressure: exercises stalls, bubbles, reset flush and a random out_ready sweep.
`timescale 1ns/1ps

module tb_barrel_shift_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_shamt;
  logic [1:0] in_op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
`ifdef BSH_ZERO_FLAG_EN
  logic       out_zero;
`endif

  always #5 clk = ~clk;

  barrel_shift_pipe #(.WIDTH(8), .SHW(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef BSH_ZERO_FLAG_EN
    ,
    .out_zero  (out_zero)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [7:0] dat;
    logic       zero;
  } exp_t;

  typedef struct {
    logic [7:0] d;
    logic [2:0] sh;
    logic [1:0] op;
    logic [7:0] exp;
  } vec_t;

  exp_t q[$];
  bit   mon_en  = 1'b0;
  bit   rnd_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Bit-by-bit reference: result bit i is selected from operand bit i-/+sh.
  function automatic logic [7:0] ref_shift(input logic [7:0] d, input logic [2:0] sh, input logic [1:0] op);
    logic [7:0] r;
    int s;
    r = '0;
    s = int'(sh);
    for (int i = 0; i < 8; i++) begin
      case (op)
        2'b00:   r[i] = (i >= s)    ? d[i-s] : 1'b0;
        2'b01:   r[i] = (i + s < 8) ? d[i+s] : 1'b0;
        2'b10:   r[i] = (i + s < 8) ? d[i+s] : d[7];
        default: r[i] = d[(i+s)%8];
      endcase
    end
    return r;
  endfunction

  // Offers one op; returns at posedge+1 after acceptance with in_valid low.
  task automatic send(input logic [7:0] d, input logic [2:0] sh, input logic [1:0] op, input logic [7:0] exp);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_shamt = sh;
    in_op    = op;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_chk++;
      $display("FAIL send_timeout: in_ready stayed 0, expected acceptance");
    end else begin
      q.push_back('{dat: exp, zero: (exp == 8'h00)});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int t = 0; t < 100 && q.size() != 0; t++) @(negedge clk);
    check(name, 32'(q.size()), 32'd0);
  endtask

  // Scoreboard: every presented result must match the oldest outstanding op.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (out_valid) begin
        if (q.size() == 0) begin
          n_chk++;
          $display("FAIL spurious_result: got 0x%0h, expected no valid output", out_data);
        end else begin
          check("result", 32'(out_data), 32'(q[0].dat));
`ifdef BSH_ZERO_FLAG_EN
          check("zero_flag", 32'(out_zero), 32'(q[0].zero));
`endif
          if (out_ready) q.delete(0);
        end
      end
      check("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
    end
  end

  vec_t       vt[14];
  logic [7:0] bd[6];
  logic [2:0] bs[6];
  logic [1:0] bo[6];
  logic       pat[8];
  logic       ov[8];
  logic [7:0] rd;
  logic [2:0] rs;
  logic [1:0] ro;

  initial begin
    vt[0]  = '{8'hB5, 3'd3, 2'b00, 8'hA8};
    vt[1]  = '{8'hB5, 3'd3, 2'b01, 8'h16};
    vt[2]  = '{8'hB5, 3'd3, 2'b10, 8'hF6};
    vt[3]  = '{8'hB5, 3'd3, 2'b11, 8'hB6};
    vt[4]  = '{8'h5A, 3'd7, 2'b10, 8'h00};
    vt[5]  = '{8'h81, 3'd0, 2'b00, 8'h81};
    vt[6]  = '{8'h81, 3'd0, 2'b01, 8'h81};
    vt[7]  = '{8'h81, 3'd0, 2'b10, 8'h81};
    vt[8]  = '{8'h81, 3'd0, 2'b11, 8'h81};
    vt[9]  = '{8'h01, 3'd7, 2'b11, 8'h02};
    vt[10] = '{8'h80, 3'd7, 2'b00, 8'h00};
    vt[11] = '{8'h80, 3'd7, 2'b10, 8'hFF};
    vt[12] = '{8'h96, 3'd5, 2'b11, 8'hB4};
    vt[13] = '{8'hC3, 3'd6, 2'b01, 8'h03};

    bd = '{8'h11, 8'h22, 8'h93, 8'hF0, 8'h0F, 8'hA5};
    bs = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
    bo = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b10};
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset held with an op offered: nothing may come out.
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hFF;
    in_shamt  = 3'd3;
    in_op     = 2'b00;
    out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
`ifdef BSH_ZERO_FLAG_EN
      check("rst_out_zero", 32'(out_zero), 32'd0);
`endif
    end
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("post_rst_out_valid", 32'(out_valid), 32'd0);
      check("post_rst_out_data", 32'(out_data), 32'd0);
    end
    mon_en = 1'b1;

    // Reset with two ops in flight: both must vanish.
    @(posedge clk);
    #1;
    send(8'hB5, 3'd3, 2'b00, 8'hA8);
    send(8'h01, 3'd7, 2'b11, 8'h02);
    rst_n = 1'b0;
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("flush_out_valid", 32'(out_valid), 32'd0);
    end

    // Directed vectors, issued back to back.
    @(posedge clk);
    #1;
    for (int i = 0; i < 14; i++) send(vt[i].d, vt[i].sh, vt[i].op, vt[i].exp);
    drain("table_drain");

    // Back-pressure: 4-cycle stall once the first result shows.
    @(posedge clk);
    #1;
    fork
      begin
        for (int i = 0; i < 6; i++) send(bd[i], bs[i], bo[i], ref_shift(bd[i], bs[i], bo[i]));
      end
      begin
        for (int t = 0; t < 20; t++) begin
          @(negedge clk);
          if (out_valid) break;
        end
        check("bp_first_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
          @(negedge clk);
          check("bp_in_ready", 32'(in_ready), 32'd0);
          check("bp_out_valid", 32'(out_valid), 32'd1);
          check("bp_hold", 32'(out_data), 32'(ref_shift(bd[1], bs[1], bo[1])));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          check("bp_drain_b2b", 32'(out_valid), 32'd1);
        end
      end
    join
    drain("bp_drain");

    // Bubbles: out_valid must replay the in_valid pattern 3 cycles later.
    @(posedge clk);
    #1;
    for (int c = 0; c < 8; c++) begin
      in_valid = pat[c];
      in_data  = 8'h3C + 8'(c);
      in_shamt = 3'(c);
      in_op    = 2'(c);
      if (pat[c]) q.push_back('{dat: ref_shift(in_data, in_shamt, in_op),
                                zero: (ref_shift(in_data, in_shamt, in_op) == 8'h00)});
      @(negedge clk);
      ov[c] = out_valid;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    for (int c = 0; c < 5; c++) check($sformatf("bubble_valid_%0d", c + 3), 32'(ov[c+3]), 32'(pat[c]));
    drain("bubble_drain");

    // Random sweep with random out_ready.
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          if ($urandom_range(0, 4) == 0) begin
            @(posedge clk);
            #1;
          end
          rd = 8'($urandom);
          rs = 3'($urandom_range(0, 7));
          ro = 2'($urandom_range(0, 3));
          send(rd, rs, ro, ref_shift(rd, rs, ro));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain("random_drain");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
